// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES types and column-slicing helpers for the cipher core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic {
        CIPH_FWD = 1'b0,
        CIPH_INV = 1'b1
    } ciph_op_e;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mix_col_state_e;

    // Swaps rows and columns so that column c lands in word c, row0 in the low byte.
    function automatic logic [127:0] aes_transpose(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[((r*4)+c)*8 +: 8] = s[((c*4)+r)*8 +: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [31:0] aes_col_get(input logic [127:0] s, input logic [1:0] c);
        logic [127:0] t;
        t = aes_transpose(s);
        return t[32*c +: 32];
    endfunction

    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_mix_columns_iter_if.sv
// ============================================================================
// Module   : aes_mix_columns_iter_if
// Purpose  : Input/output valid-ready state bus of the iterative MixColumns stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_mix_columns_iter_if;
    import aes_pkg::*;

    ciph_op_e     op_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] data_o;

    modport master (
        output op_i, in_valid_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o
    );

    modport slave (
        input  op_i, in_valid_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o
    );

endinterface

`default_nettype wire

// File: rtl/aes_mix_single_column.sv
// ============================================================================
// Module   : aes_mix_single_column
// Purpose  : MixColumns / InvMixColumns on one 32-bit column (row0 in [7:0]).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mix_single_column
    import aes_pkg::*;
(
    input  ciph_op_e    op_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] p0, p1, p2, p3;
    logic [7:0] u, v, t;

    assign a0 = data_i[7:0];
    assign a1 = data_i[15:8];
    assign a2 = data_i[23:16];
    assign a3 = data_i[31:24];

    // Inverse = forward matrix applied after the {05,00,04,00} pre-multiply.
    assign u = (op_i == CIPH_INV) ? aes_xtime(aes_xtime(a0 ^ a2)) : 8'h00;
    assign v = (op_i == CIPH_INV) ? aes_xtime(aes_xtime(a1 ^ a3)) : 8'h00;

    assign p0 = a0 ^ u;
    assign p1 = a1 ^ v;
    assign p2 = a2 ^ u;
    assign p3 = a3 ^ v;

    assign t = p0 ^ p1 ^ p2 ^ p3;

    assign data_o[7:0]   = p0 ^ t ^ aes_xtime(p0 ^ p1);
    assign data_o[15:8]  = p1 ^ t ^ aes_xtime(p1 ^ p2);
    assign data_o[23:16] = p2 ^ t ^ aes_xtime(p2 ^ p3);
    assign data_o[31:24] = p3 ^ t ^ aes_xtime(p3 ^ p0);

endmodule

`default_nettype wire

// File: rtl/aes_mix_columns_iter.sv
// ============================================================================
// Module   : aes_mix_columns_iter
// Purpose  : Iterative MixColumns stage, NUM_SC columns per cycle.
//            Optional macro AES_MIX_COLUMNS_SCRUB_EN hides non-result state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int NUM_SC = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    aes_mix_columns_iter_if.slave  bus,
    output logic                   busy_o
);

    localparam int         NUM_STEPS = 4 / NUM_SC;
    localparam logic [1:0] CNT_LAST  = 2'(NUM_STEPS - 1);

    if ((NUM_SC != 1) && (NUM_SC != 2) && (NUM_SC != 4)) begin : g_bad_num_sc
        $error("aes_mix_columns_iter: NUM_SC must be 1, 2 or 4");
    end

    mix_col_state_e state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [127:0]   data_q, data_d;
    ciph_op_e       op_q, op_d;
    logic           in_ready, out_valid;

    logic [1:0]     col_idx [NUM_SC];
    logic [31:0]    col_in  [NUM_SC];
    logic [31:0]    col_out [NUM_SC];
    logic [127:0]   mixed_t;
    logic [127:0]   mixed;

    for (genvar k = 0; k < NUM_SC; k++) begin : g_unit
        assign col_idx[k] = 2'((int'(cnt_q) * NUM_SC) + k);
        assign col_in[k]  = aes_col_get(data_q, col_idx[k]);

        aes_mix_single_column u_col (
            .op_i   (op_q),
            .data_i (col_in[k]),
            .data_o (col_out[k])
        );
    end

    // Write unit results back in place via the transposed (column-major) view.
    always_comb begin
        mixed_t = aes_transpose(data_q);
        for (int k = 0; k < NUM_SC; k++) begin
            mixed_t[32*col_idx[k] +: 32] = col_out[k];
        end
        mixed = aes_transpose(mixed_t);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        op_d      = op_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            MC_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    data_d  = bus.data_i;
                    op_d    = bus.op_i;
                    cnt_d   = 2'd0;
                    state_d = MC_BUSY;
                end
            end
            MC_BUSY: begin
                data_d = mixed;
                if (cnt_q == CNT_LAST) begin
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            MC_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = MC_IDLE;
`ifdef AES_MIX_COLUMNS_SCRUB_EN
                    data_d  = '0;
`endif
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MC_IDLE;
            cnt_q   <= 2'd0;
            data_q  <= '0;
            op_q    <= CIPH_FWD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            op_q    <= op_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign busy_o          = (state_q != MC_IDLE);

`ifdef AES_MIX_COLUMNS_SCRUB_EN
    assign bus.data_o = out_valid ? data_q : '0;
`else
    assign bus.data_o = data_q;
`endif

endmodule

`default_nettype wire

// File: doc/aes_mix_columns_iter.md
Name: aes_mix_columns_iter

Overview:
Iterative MixColumns/InvMixColumns stage for the AES cipher core datapath.
- Accepts a full 128-bit state from the upstream ShiftRows stage over a valid/ready handshake.
- Pushes the state through NUM_SC instances of aes_mix_single_column, NUM_SC columns per cycle, and returns the result to the downstream AddRoundKey stage.
- Trades latency for area against a fully parallel 4-column MixColumns.

Parameters:
NUM_SC, 1, single-column units instantiated (legal: 1, 2, 4; anything else is an elaboration error); BUSY lasts 4/NUM_SC cycles.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
op_i  in  1  0 = CIPH_FWD (MixColumns), 1 = CIPH_INV (InvMixColumns); sampled on input handshake
in_valid_i  in  1  input state valid
in_ready_o  out  1  block can accept a state
data_i  in  128  input state; byte (row r, col c) at bits [((r*4)+c)*8 +: 8]
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
data_o  out  128  result state, same byte layout as data_i
busy_o  out  1  high in BUSY or DONE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, column counter=0, state reg=0, op reg=CIPH_FWD. Outputs: in_ready_o=1, out_valid_o=0, busy_o=0, data_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready_o=1. On in_valid_i&in_ready_o:
  - latch data_i into state reg and op_i into op reg; clear counter.
  - go to BUSY.
- BUSY: in_ready_o=0. Each cycle, unit k processes column (cnt*NUM_SC+k).
  - Column assembly: column c = {row3,row2,row1,row0} bytes of column c, row0 in bits [7:0].
  - Unit result is written back in place to the state reg; counter increments.
  - When counter = 4/NUM_SC-1, the final writeback occurs and the FSM goes to DONE.
- DONE: out_valid_o=1, data_o=state reg.
  - Hold data_o stable and keep out_valid_o high until out_ready_i.
  - On out_valid_o&out_ready_i, go to IDLE.
- Latency: accept in cycle T, out_valid_o in cycle T+4/NUM_SC+1. Throughput is one state per 4/NUM_SC+2 cycles.
- in_ready_o is 0 in BUSY and DONE. in_valid_i there is ignored and not queued.
- in_ready_o does not depend combinationally on out_ready_i.
- op_i changes after acceptance have no effect on the in-flight state.
- Counter wrap: it never exceeds 4/NUM_SC-1 and resets to 0 on accept.
- Reset mid-operation: immediately returns to reset values; partial state is discarded and no out_valid_o is produced.

Optional Feature:
AES_MIX_COLUMNS_SCRUB_EN
- Defined:
  - On output handshake, the state reg is written to zero.
  - data_o is forced to 0 whenever out_valid_o=0, so no intermediate or stale state is visible.
- Undefined:
  - The state reg retains its last value after handshake.
  - data_o always drives the state reg, including intermediate columns during BUSY.

Decomposition:
- Shared aes_pkg holds:
  - ciph_op_e (CIPH_FWD=1'b0, CIPH_INV=1'b1).
  - The mix_col FSM state enum (IDLE, BUSY, DONE).
  - The aes_col_get / aes_transpose helpers used for column slicing.
- Sub-module: aes_mix_single_column, instantiated NUM_SC times in a generate loop. The op input of every instance is driven from the op reg.
- No other sub-modules.

Test Plan:
- FIPS-197 forward vector: NUM_SC=1, op=0, all columns 0x455313db -> all columns 0xbca14d8e. out_valid_o exactly 5 cycles after accept.
- Inverse round-trip: op=1, all columns 0xbca14d8e -> 0x455313db. Mixed columns {0x01010101, 0xc6c6c6c6, 0xd5d4d4d4, 0x455313db} forward -> {0x01010101, 0xc6c6c6c6, 0xd6d7d5d5, 0xbca14d8e}; applying inverse returns the original.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE.
  - data_o and out_valid_o stay stable.
  - in_valid_i pulses are ignored.
  - Release -> handshake, in_ready_o=1 next cycle.
- Parameter sweep NUM_SC=2 and NUM_SC=4 with the same vectors -> identical data_o. Latencies 3 and 2 cycles respectively.
- Reset mid-BUSY: assert rst_ni low at counter=2 -> outputs go to reset values at once; after release no out_valid_o appears; a new accept works normally.
- Scrub: with AES_MIX_COLUMNS_SCRUB_EN defined, data_o==0 during BUSY and after handshake. Without it, data_o equals the last result after handshake.
